// File: rtl/adc_ctrl_pkg.sv
// rtl/adc_ctrl_pkg.sv - shared types and constants for the ADC arbiter
package adc_ctrl_pkg;

  typedef enum logic [2:0] {
    StOff,
    StPwrup,
    StIdle,
    StConv,
    StRelease
  } arb_state_e;

  localparam logic [1:0] AdcChnSelNone = 2'b00;
  localparam logic [1:0] AdcChnSelChn0 = 2'b01;
  localparam logic [1:0] AdcChnSelChn1 = 2'b10;

endpackage

// File: rtl/adc_ctrl_rr_arb.sv
// rtl/adc_ctrl_rr_arb.sv - combinational round-robin pick starting at ptr_i
module adc_ctrl_rr_arb #(
  parameter int NumReq = 2,
  localparam int PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [PtrW-1:0]   idx_o,
  output logic              valid_o
);

  logic [PtrW:0]   sum;
  logic [PtrW-1:0] cand;

  // Walk requesters from the pointer with wraparound; first hit wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NumReq; i++) begin
      sum = {1'b0, ptr_i} + (PtrW+1)'(i);
      if (sum >= (PtrW+1)'(NumReq)) begin
        sum = sum - (PtrW+1)'(NumReq);
      end
      cand = sum[PtrW-1:0];
      if (!valid_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_ctrl_arb.sv
// rtl/adc_ctrl_arb.sv - ADC sharing arbiter with power sequencing
// Optional conversion watchdog: define ADC_CTRL_ARB_TIMEOUT_EN.
module adc_ctrl_arb
  import adc_ctrl_pkg::*;
#(
  parameter int NumReq   = 2,
  parameter int IdleW    = 8,
  parameter int TimeoutW = 10
) (
  input  logic              clk_aon_i,
  input  logic              rst_aon_ni,
  input  logic              cfg_fsm_rst_i,
  input  logic [3:0]        cfg_pwrup_time_i,
  input  logic [IdleW-1:0]  cfg_idle_time_i,
  input  logic [NumReq-1:0] req_i,
  input  logic [NumReq-1:0] req_chn_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [NumReq-1:0] rsp_valid_o,
  output logic              rsp_err_o,
  output logic [9:0]        rsp_data_o,
  output logic              adc_pd_o,
  output logic [1:0]        adc_chn_sel_o,
  input  logic [9:0]        adc_d_i,
  input  logic              adc_d_val_i,
  output logic              busy_o
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  arb_state_e        state_q, state_d;
  logic [3:0]        pwr_cnt_q;
  logic [IdleW-1:0]  idle_cnt_q;
  logic [PtrW-1:0]   ptr_q, ptr_nxt, arb_idx;
  logic [NumReq-1:0] arb_gnt, win_q, rsp_valid_q;
  logic              arb_valid, chn_q;
  logic [9:0]        rsp_data_q;
  logic              tmo_hit;

  adc_ctrl_rr_arb #(.NumReq(NumReq)) u_rr_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign ptr_nxt = (arb_idx == PtrW'(NumReq - 1)) ? '0 : arb_idx + PtrW'(1);

`ifdef ADC_CTRL_ARB_TIMEOUT_EN
  logic [TimeoutW-1:0] tmo_cnt_q;
  logic                rsp_err_q;

  assign tmo_hit   = (&tmo_cnt_q) && !adc_d_val_i;
  assign rsp_err_o = rsp_err_q;

  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else if (cfg_fsm_rst_i) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= 1'b0;
      if (state_q == StConv) begin
        if (adc_d_val_i || tmo_hit) begin
          tmo_cnt_q <= '0;
          rsp_err_q <= tmo_hit;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + TimeoutW'(1);
        end
      end
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^{TimeoutW{1'b0}};
  assign tmo_hit    = 1'b0;
  assign rsp_err_o  = 1'b0;
`endif

  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      state_q <= StOff;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOff:     if (|req_i) state_d = StPwrup;
      StPwrup:   if (pwr_cnt_q == cfg_pwrup_time_i) state_d = StIdle;
      StIdle: begin
        if (arb_valid) begin
          state_d = StConv;
        end else if (idle_cnt_q == cfg_idle_time_i) begin
          state_d = StOff;
        end
      end
      StConv:    if (adc_d_val_i || tmo_hit) state_d = StRelease;
      StRelease: if (!adc_d_val_i) state_d = StIdle;
      default:   state_d = StOff;
    endcase
    if (cfg_fsm_rst_i) begin
      state_d = StOff;
    end
  end

  always_comb begin
    adc_pd_o      = 1'b0;
    adc_chn_sel_o = AdcChnSelNone;
    busy_o        = 1'b0;
    gnt_o         = '0;
    unique case (state_q)
      StOff:     adc_pd_o = 1'b1;
      StIdle:    gnt_o = cfg_fsm_rst_i ? '0 : arb_gnt;
      StConv: begin
        adc_chn_sel_o = chn_q ? AdcChnSelChn1 : AdcChnSelChn0;
        busy_o        = 1'b1;
      end
      StRelease: busy_o = 1'b1;
      default:   adc_pd_o = (state_q != StPwrup);
    endcase
  end

  // Counters, winner latch and response registers.
  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      pwr_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      ptr_q       <= '0;
      win_q       <= '0;
      chn_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else if (cfg_fsm_rst_i) begin
      pwr_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      ptr_q       <= '0;
      win_q       <= '0;
      chn_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        StPwrup: begin
          pwr_cnt_q <= (pwr_cnt_q == cfg_pwrup_time_i) ? 4'd0 : pwr_cnt_q + 4'd1;
        end
        StIdle: begin
          if (arb_valid) begin
            win_q      <= arb_gnt;
            chn_q      <= req_chn_i[arb_idx];
            ptr_q      <= ptr_nxt;
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == cfg_idle_time_i) begin
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + IdleW'(1);
          end
        end
        StConv: begin
          if (adc_d_val_i) begin
            rsp_data_q  <= adc_d_i;
            rsp_valid_q <= win_q;
          end else if (tmo_hit) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= win_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_adc_ctrl_arb.sv
// tb/tb_adc_ctrl_arb.sv - directed self-checking bench for adc_ctrl_arb
module tb_adc_ctrl_arb;

  logic       clk_aon_i = 1'b0;
  logic       rst_aon_ni;
  logic       cfg_fsm_rst_i;
  logic [3:0] cfg_pwrup_time_i;
  logic [7:0] cfg_idle_time_i;
  logic [1:0] req_i, req_chn_i, gnt_o, rsp_valid_o;
  logic       rsp_err_o, adc_pd_o, adc_d_val_i, busy_o;
  logic [9:0] rsp_data_o, adc_d_i;
  logic [1:0] adc_chn_sel_o;

  int total = 0;
  int bad   = 0;

  adc_ctrl_arb #(.NumReq(2), .IdleW(8), .TimeoutW(4)) dut (
    .clk_aon_i        (clk_aon_i),
    .rst_aon_ni       (rst_aon_ni),
    .cfg_fsm_rst_i    (cfg_fsm_rst_i),
    .cfg_pwrup_time_i (cfg_pwrup_time_i),
    .cfg_idle_time_i  (cfg_idle_time_i),
    .req_i            (req_i),
    .req_chn_i        (req_chn_i),
    .gnt_o            (gnt_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_err_o        (rsp_err_o),
    .rsp_data_o       (rsp_data_o),
    .adc_pd_o         (adc_pd_o),
    .adc_chn_sel_o    (adc_chn_sel_o),
    .adc_d_i          (adc_d_i),
    .adc_d_val_i      (adc_d_val_i),
    .busy_o           (busy_o)
  );

  always #5 clk_aon_i = ~clk_aon_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_aon_i);
    #1;
  endtask

  logic [1:0] exp_gnt [4];
  logic [1:0] exp_sel [4];
  logic [9:0] d_vec   [4];

  initial begin
    exp_gnt = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_sel = '{2'b10, 2'b01, 2'b10, 2'b01};
    d_vec   = '{10'h001, 10'h3fe, 10'h2aa, 10'h155};

    rst_aon_ni = 1'b0; cfg_fsm_rst_i = 1'b0;
    cfg_pwrup_time_i = 4'd3; cfg_idle_time_i = 8'd5;
    req_i = '0; req_chn_i = '0; adc_d_i = '0; adc_d_val_i = 1'b0;
    tick(); tick();
    check("rst_pd", adc_pd_o, 1);
    check("rst_sel", adc_chn_sel_o, 0);
    check("rst_gnt", gnt_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_err", rsp_err_o, 0);
    check("rst_data", rsp_data_o, 0);
    check("rst_busy", busy_o, 0);
    rst_aon_ni = 1'b1;

    // Power-up then first conversion on chn0
    req_i = 2'b01; req_chn_i = 2'b00; #1;
    check("t1_off_pd", adc_pd_o, 1);
    check("t1_off_gnt", gnt_o, 0);
    tick();
    check("t1_pwrup_pd", adc_pd_o, 0);
    tick(); tick(); tick();
    check("t1_pwrup_last_gnt", gnt_o, 0);
    tick();
    check("t1_gnt", gnt_o, 2'b01);
    tick();
    check("t1_sel", adc_chn_sel_o, 2'b01);
    check("t1_busy", busy_o, 1);
    req_i = '0; adc_d_i = 10'h155; adc_d_val_i = 1'b1; #1;
    check("t1_rsp_early", rsp_valid_o, 0);
    tick();
    check("t1_rsp_valid", rsp_valid_o, 2'b01);
    check("t1_rsp_data", rsp_data_o, 10'h155);
    check("t1_rel_sel", adc_chn_sel_o, 0);
    check("t1_rel_busy", busy_o, 1);
    adc_d_val_i = 1'b0;
    tick();
    check("t1_rsp_pulse", rsp_valid_o, 0);
    check("t1_idle_busy", busy_o, 0);
    check("t1_data_hold", rsp_data_o, 10'h155);

    // Both requesters held: grants alternate from pointer=1
    for (int k = 0; k < 4; k++) begin
      req_i = 2'b11; req_chn_i = 2'b10; #1;
      check("t2_gnt", gnt_o, exp_gnt[k]);
      tick();
      check("t2_sel", adc_chn_sel_o, exp_sel[k]);
      check("t2_conv_gnt", gnt_o, 0);
      tick();
      check("t2_wait_sel", adc_chn_sel_o, exp_sel[k]);
      adc_d_i = d_vec[k]; adc_d_val_i = 1'b1;
      tick();
      check("t2_rsp_valid", rsp_valid_o, exp_gnt[k]);
      check("t2_rsp_data", rsp_data_o, d_vec[k]);
      check("t2_rel_sel", adc_chn_sel_o, 0);
      tick();
      check("t2_rel_hold_busy", busy_o, 1);
      check("t2_rel_hold_gnt", gnt_o, 0);
      adc_d_val_i = 1'b0;
      tick();
    end

    // Idle power-down after 6 idle cycles
    req_i = '0;
    for (int i = 0; i < 6; i++) begin
      check("t3_idle_pd", adc_pd_o, 0);
      tick();
    end
    check("t3_pd", adc_pd_o, 1);
    req_i = 2'b01; req_chn_i = 2'b00;
    tick();
    req_i = '0;
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_idle_gnt", gnt_o, 0);
      tick();
    end
    req_i = 2'b01; #1;
    check("t3_last_idle_gnt", gnt_o, 2'b01);
    check("t3_last_idle_pd", adc_pd_o, 0);
    tick();
    check("t3_conv_pd", adc_pd_o, 0);
    check("t3_conv_busy", busy_o, 1);
    req_i = '0; adc_d_i = 10'h2aa; adc_d_val_i = 1'b1;
    tick();
    check("t3_rsp_valid", rsp_valid_o, 2'b01);
    adc_d_val_i = 1'b0;
    tick();

    // Requester 1 withdraws before being granted
    req_i = 2'b01; req_chn_i = 2'b00; #1;
    check("t5_gnt0", gnt_o, 2'b01);
    tick();
    req_i = 2'b10; req_chn_i = 2'b10; #1;
    check("t5_conv_gnt", gnt_o, 0);
    tick();
    req_i = '0; adc_d_i = 10'h0f0; adc_d_val_i = 1'b1;
    tick();
    check("t5_rsp_valid", rsp_valid_o, 2'b01);
    adc_d_val_i = 1'b0;
    tick();
    check("t5_idle_gnt", gnt_o, 0);
    check("t5_idle_rsp", rsp_valid_o, 0);
    tick();
    check("t5_idle_rsp2", rsp_valid_o, 0);
    check("t5_idle_pd", adc_pd_o, 0);

    // Soft reset during a conversion
    req_i = 2'b01; req_chn_i = 2'b00; #1;
    check("t4_gnt", gnt_o, 2'b01);
    tick();
    check("t4_sel", adc_chn_sel_o, 2'b01);
    cfg_fsm_rst_i = 1'b1; req_i = '0; adc_d_i = 10'h3ff; adc_d_val_i = 1'b1; #1;
    check("t4_rst_gnt", gnt_o, 0);
    tick();
    cfg_fsm_rst_i = 1'b0; adc_d_val_i = 1'b0;
    check("t4_pd", adc_pd_o, 1);
    check("t4_sel_off", adc_chn_sel_o, 0);
    check("t4_busy", busy_o, 0);
    check("t4_rsp_valid", rsp_valid_o, 0);
    check("t4_data_clr", rsp_data_o, 0);
    tick();
    check("t4_rsp_valid2", rsp_valid_o, 0);
    req_i = 2'b11; req_chn_i = 2'b00;
    tick(); tick(); tick(); tick(); tick();
    check("t4_ptr_reset", gnt_o, 2'b01);
    tick();
    req_i = '0; adc_d_i = 10'h123; adc_d_val_i = 1'b1;
    tick();
    check("t4_rsp_valid3", rsp_valid_o, 2'b01);
    check("t4_rsp_data3", rsp_data_o, 10'h123);
    adc_d_val_i = 1'b0;
    tick();

`ifdef ADC_CTRL_ARB_TIMEOUT_EN
    // Watchdog abort with TimeoutW=4
    req_i = 2'b01; #1;
    check("t6_gnt", gnt_o, 2'b01);
    tick();
    req_i = '0;
    repeat (15) tick();
    check("t6_no_rsp_yet", rsp_valid_o, 0);
    check("t6_still_conv", busy_o, 1);
    tick();
    check("t6_rsp_valid", rsp_valid_o, 2'b01);
    check("t6_rsp_err", rsp_err_o, 1);
    check("t6_rsp_data", rsp_data_o, 0);
    tick();
    check("t6_err_pulse", rsp_err_o, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
